// File: rtl/pmp_pkg.sv
// Shared types, constants and the permission rule for the sequential PMP checker.
package pmp_pkg;

    typedef struct packed {
        logic       l;
        logic [1:0] rsvd;
        logic [1:0] a;
        logic       x;
        logic       w;
        logic       r;
    } pmpcfg_t;

    localparam logic [1:0] A_OFF   = 2'b00;
    localparam logic [1:0] A_TOR   = 2'b01;
    localparam logic [1:0] A_NA4   = 2'b10;
    localparam logic [1:0] A_NAPOT = 2'b11;

    localparam logic [1:0] ACC_R = 2'b00;
    localparam logic [1:0] ACC_W = 2'b01;
    localparam logic [1:0] ACC_X = 2'b10;

    localparam logic [1:0] PRIV_M = 2'b11;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_U = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_RESP
    } state_t;

    // Reserved access type is always denied; a miss only lets machine mode through.
    function automatic logic pmp_allow(input logic hit, input pmpcfg_t cfg,
                                       input logic [1:0] acc, input logic [1:0] priv);
        logic perm;
        case (acc)
            ACC_R:   perm = cfg.r;
            ACC_W:   perm = cfg.w;
            ACC_X:   perm = cfg.x;
            default: perm = 1'b0;
        endcase
        if (acc == 2'b11)
            return 1'b0;
        if (!hit)
            return priv == PRIV_M;
        if (priv == PRIV_M && !cfg.l)
            return 1'b1;
        return perm;
    endfunction

endpackage

// File: rtl/pmp_entry_match.sv
// Address match for a single PMP entry (TOR always; NA4/NAPOT only when PMP_NAPOT_EN).
module pmp_entry_match
    import pmp_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  pmpcfg_t         cfg,
    input  logic [XLEN-1:0] pmpaddr,
    input  logic [XLEN-1:0] prev_pmpaddr,
    input  logic            is_first,
    input  logic [XLEN-3:0] wa,
    output logic            match
);

    logic [XLEN-3:0] pa;
    logic [XLEN-3:0] lo;
    logic            unused_bits;

    assign pa = pmpaddr[XLEN-3:0];
    assign lo = is_first ? '0 : prev_pmpaddr[XLEN-3:0];
    assign unused_bits = ^{pmpaddr[XLEN-1:XLEN-2], prev_pmpaddr[XLEN-1:XLEN-2],
                           cfg.l, cfg.rsvd, cfg.x, cfg.w, cfg.r};

`ifdef PMP_NAPOT_EN
    localparam logic [XLEN-3:0] ONE = 1;
    logic [XLEN-3:0] napot_mask;

    // pa ^ (pa+1) sets exactly the trailing ones plus the first zero: the k+1 ignored bits.
    assign napot_mask = ~(pa ^ (pa + ONE));
`endif

    always_comb begin
        // NOTE: default assignment first so every path drives match; no latch is inferred.
        match = 1'b0;
        case (cfg.a)
            A_TOR:   match = (wa >= lo) && (wa < pa);
`ifdef PMP_NAPOT_EN
            A_NA4:   match = (wa == pa);
            A_NAPOT: match = ((wa & napot_mask) == (pa & napot_mask));
`endif
            default: match = 1'b0;
        endcase
    end

endmodule

// File: rtl/pmp_seq_checker.sv
// Iterative PMP checker: scans one entry per cycle, lowest matching index wins.
// Optional NA4/NAPOT matching is built only when PMP_NAPOT_EN is defined.
module pmp_seq_checker
    import pmp_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int XLEN        = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [XLEN-1:0]             req_addr,
    input  logic [1:0]                  req_type,
    input  logic [1:0]                  req_priv,
    input  logic [8*NUM_ENTRIES-1:0]    pmpcfg_flat,
    input  logic [XLEN*NUM_ENTRIES-1:0] pmpaddr_flat,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_allow,
    output logic                        rsp_hit,
    output logic [3:0]                  rsp_entry
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ENTRIES - 1);

    state_t          state;
    logic [3:0]      idx;
    logic [3:0]      prev_idx;
    logic [XLEN-3:0] wa_q;
    logic [1:0]      type_q;
    logic [1:0]      priv_q;
    pmpcfg_t         cur_cfg;
    logic [XLEN-1:0] cur_addr;
    logic [XLEN-1:0] prev_addr;
    logic            is_first;
    logic            entry_match;
    logic            unused_addr_lsb;

    assign unused_addr_lsb = ^req_addr[1:0];

    // Single shared matcher, steered by the scan index.
    assign is_first  = (idx == 4'd0);
    assign prev_idx  = is_first ? 4'd0 : idx - 4'd1;
    assign cur_cfg   = pmpcfg_t'(pmpcfg_flat[{idx, 3'b000} +: 8]);
    assign cur_addr  = pmpaddr_flat[int'(idx) * XLEN +: XLEN];
    assign prev_addr = pmpaddr_flat[int'(prev_idx) * XLEN +: XLEN];

    pmp_entry_match #(
        .XLEN(XLEN)
    ) u_match (
        .cfg          (cur_cfg),
        .pmpaddr      (cur_addr),
        .prev_pmpaddr (prev_addr),
        .is_first     (is_first),
        .wa           (wa_q),
        .match        (entry_match)
    );

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: request latches are reset too; cheap, and keeps the datapath free of X.
            state     <= ST_IDLE;
            idx       <= '0;
            wa_q      <= '0;
            type_q    <= '0;
            priv_q    <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_allow <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_entry <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        wa_q      <= req_addr[XLEN-1:2];
                        type_q    <= req_type;
                        priv_q    <= req_priv;
                        idx       <= '0;
                        req_ready <= 1'b0;
                        state     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (entry_match) begin
                        rsp_hit   <= 1'b1;
                        rsp_entry <= idx;
                        rsp_allow <= pmp_allow(1'b1, cur_cfg, type_q, priv_q);
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else if (idx == LAST_IDX) begin
                        rsp_hit   <= 1'b0;
                        rsp_entry <= '0;
                        rsp_allow <= pmp_allow(1'b0, cur_cfg, type_q, priv_q);
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmp_seq_checker.sv
// Self-checking bench for pmp_seq_checker: directed scenarios plus randomized configs vs a range-based model.
module tb_pmp_seq_checker;

    localparam int N = 16;
    localparam int XL = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [XL-1:0]   req_addr;
    logic [1:0]      req_type;
    logic [1:0]      req_priv;
    logic [8*N-1:0]  cfg_flat;
    logic [XL*N-1:0] addr_flat;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_allow;
    logic            rsp_hit;
    logic [3:0]      rsp_entry;

    int errors = 0;
    int checks = 0;

    pmp_seq_checker #(.NUM_ENTRIES(N), .XLEN(XL)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_type     (req_type),
        .req_priv     (req_priv),
        .pmpcfg_flat  (cfg_flat),
        .pmpaddr_flat (addr_flat),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_allow    (rsp_allow),
        .rsp_hit      (rsp_hit),
        .rsp_entry    (rsp_entry)
    );

    always #5 clk = ~clk;

    // Reference model: each entry describes a word range [base, base+size) or a single word.
    function automatic bit ref_entry_hit(input int i, input longint wa);
        logic [7:0] c;
        longint pa, lo, size, base;
        int k;
        c  = cfg_flat[8*i +: 8];
        pa = longint'(addr_flat[XL*i +: XL-2]);
        lo = (i == 0) ? 0 : longint'(addr_flat[XL*(i-1) +: XL-2]);
        case (c[4:3])
            2'b01: return (wa >= lo) && (wa < pa);
`ifdef PMP_NAPOT_EN
            2'b10: return wa == pa;
            2'b11: begin
                k = 0;
                while (k < XL-2 && pa[k]) k++;
                size = longint'(1) << (k + 1);
                base = pa - (pa % size);
                return (wa >= base) && (wa < base + size);
            end
`endif
            default: return 1'b0;
        endcase
    endfunction

    task automatic ref_eval(input logic [31:0] a, input logic [1:0] t, input logic [1:0] p,
                            output bit hit, output int entry, output bit allow, output int lat);
        logic [7:0] c;
        hit = 0; entry = 0; c = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (!hit && ref_entry_hit(i, longint'(a[31:2]))) begin
                hit = 1; entry = i; c = cfg_flat[8*i +: 8];
            end
        end
        if (t == 2'b11)                allow = 0;
        else if (!hit)                 allow = (p == 2'b11);
        else if (p == 2'b11 && !c[7])  allow = 1;
        else                           allow = c[t];
        lat = hit ? entry + 1 : N;
    endtask

    task automatic clear_cfg();
        cfg_flat = '0;
        addr_flat = '0;
    endtask

    task automatic set_entry(input int i, input logic [7:0] c, input logic [31:0] a);
        cfg_flat[8*i +: 8] = c;
        addr_flat[XL*i +: XL] = a;
    endtask

    // Drives one request and waits (bounded) for rsp_valid; lat = -1 on timeout.
    task automatic start_req(input logic [31:0] a, input logic [1:0] t, input logic [1:0] p,
                             output int lat);
        int n;
        n = 0;
        while (!req_ready && n < 40) begin @(posedge clk); #1; n++; end
        req_addr = a; req_type = t; req_priv = p; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        if (!rsp_valid) lat = -1;
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic setup_tor();
        clear_cfg();
        set_entry(2, 8'h00, 32'h400);
        set_entry(3, 8'h09, 32'h800);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_hit !== 1'b0)   begin errors++; $display("FAIL reset_rsp_hit: got %b expected 0", rsp_hit); end
        checks++; if (rsp_allow !== 1'b0) begin errors++; $display("FAIL reset_rsp_allow: got %b expected 0", rsp_allow); end
        checks++; if (rsp_entry !== 4'd0) begin errors++; $display("FAIL reset_rsp_entry: got %0d expected 0", rsp_entry); end
    endtask

    task automatic test_tor();
        int lat;
        setup_tor();
        start_req(32'h0000_1000, 2'b00, 2'b00, lat);
        checks++; if (lat != 4)           begin errors++; $display("FAIL tor_read_latency: got %0d expected 4", lat); end
        checks++; if (rsp_hit !== 1'b1)   begin errors++; $display("FAIL tor_read_hit: got %b expected 1", rsp_hit); end
        checks++; if (rsp_entry !== 4'd3) begin errors++; $display("FAIL tor_read_entry: got %0d expected 3", rsp_entry); end
        checks++; if (rsp_allow !== 1'b1) begin errors++; $display("FAIL tor_read_allow: got %b expected 1", rsp_allow); end
        ack_rsp();
        start_req(32'h0000_1000, 2'b01, 2'b00, lat);
        checks++; if (rsp_hit !== 1'b1)   begin errors++; $display("FAIL tor_write_hit: got %b expected 1", rsp_hit); end
        checks++; if (rsp_entry !== 4'd3) begin errors++; $display("FAIL tor_write_entry: got %0d expected 3", rsp_entry); end
        checks++; if (rsp_allow !== 1'b0) begin errors++; $display("FAIL tor_write_allow: got %b expected 0", rsp_allow); end
        ack_rsp();
    endtask

    task automatic test_all_off();
        int lat;
        clear_cfg();
        start_req(32'h0000_1000, 2'b00, 2'b00, lat);
        checks++; if (lat != N)           begin errors++; $display("FAIL off_latency: got %0d expected %0d", lat, N); end
        checks++; if (rsp_hit !== 1'b0)   begin errors++; $display("FAIL off_hit: got %b expected 0", rsp_hit); end
        checks++; if (rsp_entry !== 4'd0) begin errors++; $display("FAIL off_entry: got %0d expected 0", rsp_entry); end
        checks++; if (rsp_allow !== 1'b0) begin errors++; $display("FAIL off_u_allow: got %b expected 0", rsp_allow); end
        ack_rsp();
        start_req(32'h0000_1000, 2'b00, 2'b11, lat);
        checks++; if (rsp_allow !== 1'b1) begin errors++; $display("FAIL off_m_allow: got %b expected 1", rsp_allow); end
        ack_rsp();
    endtask

    task automatic test_napot();
        int lat;
        bit exp_hit, exp_allow;
        int exp_lat;
`ifdef PMP_NAPOT_EN
        exp_hit = 1; exp_allow = 0; exp_lat = 1;
`else
        exp_hit = 0; exp_allow = 1; exp_lat = N;
`endif
        clear_cfg();
        set_entry(0, 8'h9B, 32'h0000_01FF);
        start_req(32'h0000_0FFC, 2'b10, 2'b11, lat);
        checks++; if (lat != exp_lat)        begin errors++; $display("FAIL napot_in_latency: got %0d expected %0d", lat, exp_lat); end
        checks++; if (rsp_hit !== exp_hit)   begin errors++; $display("FAIL napot_in_hit: got %b expected %b", rsp_hit, exp_hit); end
        checks++; if (rsp_entry !== 4'd0)    begin errors++; $display("FAIL napot_in_entry: got %0d expected 0", rsp_entry); end
        checks++; if (rsp_allow !== exp_allow) begin errors++; $display("FAIL napot_in_allow: got %b expected %b", rsp_allow, exp_allow); end
        ack_rsp();
        start_req(32'h0000_1000, 2'b10, 2'b11, lat);
        checks++; if (rsp_hit !== 1'b0)   begin errors++; $display("FAIL napot_out_hit: got %b expected 0", rsp_hit); end
        checks++; if (rsp_allow !== 1'b1) begin errors++; $display("FAIL napot_out_allow: got %b expected 1", rsp_allow); end
        ack_rsp();
    endtask

    task automatic test_overlap();
        int lat;
        clear_cfg();
        set_entry(0, 8'h00, 32'h0);
        set_entry(1, 8'h08, 32'h800);
        set_entry(4, 8'h00, 32'h0);
        set_entry(5, 8'h09, 32'h800);
        start_req(32'h0000_1000, 2'b00, 2'b00, lat);
        checks++; if (lat != 2)           begin errors++; $display("FAIL overlap_latency: got %0d expected 2", lat); end
        checks++; if (rsp_entry !== 4'd1) begin errors++; $display("FAIL overlap_entry: got %0d expected 1", rsp_entry); end
        checks++; if (rsp_allow !== 1'b0) begin errors++; $display("FAIL overlap_allow: got %b expected 0", rsp_allow); end
        ack_rsp();
    endtask

    task automatic test_backpressure();
        int lat;
        setup_tor();
        start_req(32'h0000_1000, 2'b00, 2'b00, lat);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || rsp_entry !== 4'd3 ||
                rsp_allow !== 1'b1 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got v=%b h=%b e=%0d a=%b rdy=%b expected v=1 h=1 e=3 a=1 rdy=0",
                         c, rsp_valid, rsp_hit, rsp_entry, rsp_allow, req_ready);
            end
        end
        ack_rsp();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", rsp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_reset_mid_scan();
        bit seen;
        clear_cfg();
        req_addr = 32'h0000_1000; req_type = 2'b00; req_priv = 2'b00; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_scan_valid: got %b expected 0", rsp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_scan_ready: got %b expected 1", req_ready); end
        rst = 1'b0;
        seen = 0;
        repeat (20) begin @(posedge clk); #1; if (rsp_valid) seen = 1; end
        checks++; if (seen) begin errors++; $display("FAIL rst_scan_no_rsp: got response expected none"); end
    endtask

    task automatic test_random();
        int lat, exp_entry, exp_lat, k;
        bit exp_hit, exp_allow;
        logic [31:0] a, pa;
        logic [1:0] t, p, am;
        for (int n = 0; n < 48; n++) begin
            if (n % 4 == 0) begin
                for (int i = 0; i < N; i++) begin
                    am = 2'($urandom_range(0, 3));
                    if (am == 2'b11) begin
                        k  = $urandom_range(0, 5);
                        pa = ($urandom_range(0, 63) << (k + 1)) | ((32'd1 << k) - 1);
                    end else begin
                        pa = $urandom_range(0, 255);
                    end
                    set_entry(i, {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), am,
                                  3'($urandom_range(0, 7))}, pa);
                end
            end
            a = ($urandom_range(0, 255) << 2) | $urandom_range(0, 3);
            t = 2'($urandom_range(0, 3));
            p = 2'($urandom_range(0, 3));
            ref_eval(a, t, p, exp_hit, exp_entry, exp_allow, exp_lat);
            start_req(a, t, p, lat);
            checks++; if (lat != exp_lat) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", n, lat, exp_lat); end
            checks++; if (rsp_hit !== exp_hit) begin errors++; $display("FAIL rnd%0d_hit: got %b expected %b", n, rsp_hit, exp_hit); end
            checks++; if (rsp_entry !== 4'(exp_entry)) begin errors++; $display("FAIL rnd%0d_entry: got %0d expected %0d", n, rsp_entry, exp_entry); end
            checks++; if (rsp_allow !== exp_allow) begin errors++; $display("FAIL rnd%0d_allow: got %b expected %b", n, rsp_allow, exp_allow); end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            ack_rsp();
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_addr = '0;
        req_type = '0;
        req_priv = '0;
        rsp_ready = 1'b0;
        cfg_flat = '0;
        addr_flat = '0;
        test_reset();
        test_tor();
        test_all_off();
        test_napot();
        test_overlap();
        test_backpressure();
        test_reset_mid_scan();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pmp_seq_checker.md
Name: pmp_seq_checker

Overview:
- Sequential PMP permission checker; one PMP entry evaluated per cycle, lowest-numbered matching entry wins.
- Sits between the load/store/fetch request path and the PMP CSR outputs; replaces a 16-wide parallel priority match with a small iterative datapath.
- Valid/ready handshake on both the request and response sides; one check in flight.

Parameters:
- NUM_ENTRIES, 16, number of PMP entries scanned (1..16).
- XLEN, 32, address and pmpaddr width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  check request valid.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_addr  in  XLEN  byte address to check.
- req_type  in  2  access type: 00 read, 01 write, 10 execute, 11 reserved (always denied).
- req_priv  in  2  privilege mode: 11 machine, 01 supervisor, 00 user.
- pmpcfg_flat  in  8*NUM_ENTRIES  packed cfg bytes; entry i at bits [8i+7:8i].
- pmpaddr_flat  in  XLEN*NUM_ENTRIES  packed pmpaddr; entry i at bits [XLEN*i+XLEN-1:XLEN*i].
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_allow  out  1  1 = access permitted.
- rsp_hit  out  1  1 = some entry matched.
- rsp_entry  out  4  index of matching entry; 0 when rsp_hit=0.

Behaviour:
- Cfg byte fields: [7] L, [4:3] A (00 OFF, 01 TOR, 10 NA4, 11 NAPOT), [2] X, [1] W, [0] R. Bits [6:5] are ignored.
- Match uses word address wa = req_addr[XLEN-1:2] against pmpaddr[XLEN-3:0].
  - TOR: lower bound <= wa < upper bound, unsigned. Lower bound is pmpaddr[i-1], or 0 for entry 0.
  - NA4: wa == pmpaddr.
  - NAPOT: with k = number of trailing ones in pmpaddr, compare wa and pmpaddr with the low k+1 bits masked.
  - OFF: never matches, but still consumes its scan cycle.
- FSM states IDLE, SCAN, RESP.
  - IDLE: req_ready=1. On req_valid, latch addr/type/priv, set idx=0, go to SCAN.
  - SCAN: evaluate entry idx. On match, latch result and go to RESP. Else if idx==NUM_ENTRIES-1, latch the no-match result and go to RESP. Else idx++.
  - RESP: rsp_valid=1, outputs held stable. On rsp_ready, go to IDLE. A new request can be accepted on the cycle after that.
- Latency: first match at entry k gives rsp_valid k+1 cycles after the accept edge. No match gives NUM_ENTRIES cycles.
- Permission on match:
  - req_priv==11 and L==0: allow.
  - Otherwise allow iff the R/W/X bit selected by req_type is set.
- No match: allow iff req_priv==11.
- req_type==11 is denied regardless of privilege.
- Config inputs must be stable from accept until the response handshake. The block does not snapshot them, and changing them mid-scan gives an undefined result.
- Reset values: state=IDLE, idx=0, rsp_valid=0, rsp_allow=0, rsp_hit=0, rsp_entry=0, req_ready=1 after reset deasserts. Reset mid-SCAN or mid-RESP drops the request with no response.
- req_valid is ignored outside IDLE. rsp_ready is ignored outside RESP.

Optional Feature:
- Macro PMP_NAPOT_EN.
- Defined: NA4 and NAPOT match as described above.
- Undefined: the NAPOT mask logic is not built, and A=10/11 are treated as OFF (never match). TOR and OFF behave the same in both builds.

Decomposition:
- Package pmp_pkg holds:
  - pmpcfg_t packed struct {L, rsvd[1:0], A[1:0], X, W, R};
  - A-field localparams A_OFF, A_TOR, A_NA4, A_NAPOT;
  - access-type constants ACC_R, ACC_W, ACC_X;
  - privilege constants PRIV_M, PRIV_S, PRIV_U;
  - FSM state enum.
- Sub-module pmp_entry_match: combinational. Inputs: cfg, pmpaddr, previous pmpaddr, is_first, word addr. Output: match. Instantiated once and fed by the idx mux.

Test Plan:
- U-mode read 0x0000_1000; entry 3 TOR, pmpaddr2=0x400, pmpaddr3=0x800, cfg3 R=1; other entries OFF -> rsp_valid 4 cycles after accept, rsp_hit=1, rsp_entry=3, rsp_allow=1.
- Same setup with a U-mode write -> rsp_hit=1, rsp_entry=3, rsp_allow=0.
- All entries OFF: U-mode read -> rsp_valid after 16 cycles, rsp_hit=0, rsp_entry=0, rsp_allow=0. M-mode read -> rsp_allow=1.
- Entry 0 NAPOT pmpaddr0=0x0000_01FF (4 KiB at 0), cfg0 L=1 with X=0; M-mode execute 0x0000_0FFC -> rsp_entry=0, rsp_allow=0. Execute 0x1000 -> rsp_hit=0, rsp_allow=1. Build without PMP_NAPOT_EN -> first case gives rsp_hit=0.
- Overlap: entries 1 and 5 both match, entry 1 R=0 and entry 5 R=1; U-mode read -> rsp_entry=1, rsp_allow=0 (lowest index wins).
- Backpressure and reset:
  - rsp_ready held 0 for 5 cycles -> rsp outputs stable, req_ready=0.
  - rst asserted on the 3rd SCAN cycle -> next cycle IDLE, rsp_valid=0, req_ready=1, no response emitted.
